// File: rtl/wb_queue.sv
// Writeback queue: a small circular FIFO of pending register-file writes that
// drains through the single write port and forwards pending values to readers.
module wb_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_wr,
  input  logic                       in_jal_ra,
  input  logic [W-1:0]               in_data,
  input  logic                       wb_stall,
  output logic                       regwrite,
  output logic [4:0]                 wr_out,
  output logic [W-1:0]               write_data_out,
  input  logic [4:0]                 rr1_in,
  input  logic [4:0]                 rr2_in,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [W-1:0]               fwd1_data,
  output logic [W-1:0]               fwd2_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on occupancy, never on wb_stall or a same-cycle pop.

  logic [4:0]    dest_q [DEPTH];
  logic [4:0]    dest_d [DEPTH];
  logic [W-1:0]  data_q [DEPTH];
  logic [W-1:0]  data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [4:0] eff_dest;
  logic       push;
  logic       pop;

  always_comb begin
    eff_dest = in_jal_ra ? 5'd31 : in_wr;
    in_ready = (count_q < CW'(DEPTH));
    // Writes to r0 complete the handshake but are dropped here.
    push     = in_valid && in_ready && (eff_dest != 5'd0);
    pop      = (count_q != '0) && !wb_stall;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      dest_d[i] = dest_q[i];
      data_d[i] = data_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      dest_d[tail_q] = eff_dest;
      data_d[tail_q] = in_data;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= dest_d[i];
        data_q[i] <= data_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    regwrite       = pop;
    wr_out         = (count_q != '0) ? dest_q[head_q] : 5'd0;
    write_data_out = (count_q != '0) ? data_q[head_q] : '0;
    count          = count_q;
  end

  // Walk from head to tail so the newest matching entry wins.
  logic [PW-1:0] idx;
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((rr1_in != 5'd0) && (dest_q[idx] == rr1_in)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if ((rr2_in != 5'd0) && (dest_q[idx] == rr2_in)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a per-cycle vector table plus hand-written
// sequences for reset behaviour and pointer wrap-around.
module tb_wb_queue;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          in_valid, in_ready, in_jal_ra, wb_stall, regwrite;
  logic [4:0]    in_wr, wr_out, rr1_in, rr2_in;
  logic [W-1:0]  in_data, write_data_out, fwd1_data, fwd2_data;
  logic          fwd1_hit, fwd2_hit;
  logic [2:0]    count;

  wb_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr),
    .in_jal_ra(in_jal_ra), .in_data(in_data), .wb_stall(wb_stall),
    .regwrite(regwrite), .wr_out(wr_out), .write_data_out(write_data_out),
    .rr1_in(rr1_in), .rr2_in(rr2_in),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .count(count)
  );

  typedef struct {
    logic        v;
    logic [4:0]  wr;
    logic        jal;
    logic [31:0] d;
    logic        st;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t        vecs[$];
  logic [W-1:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic vec_t mk(
    input logic v, input logic [4:0] wr, input logic jal, input logic [31:0] d,
    input logic st, input logic [4:0] r1, input logic [4:0] r2,
    input logic e_rdy, input logic e_rw, input logic [4:0] e_wr,
    input logic [31:0] e_wd, input logic e_h1, input logic [31:0] e_d1,
    input logic e_h2, input logic [31:0] e_d2, input logic [2:0] e_cnt);
    vec_t t;
    t.v = v; t.wr = wr; t.jal = jal; t.d = d; t.st = st; t.r1 = r1; t.r2 = r2;
    t.e_rdy = e_rdy; t.e_rw = e_rw; t.e_wr = e_wr; t.e_wd = e_wd;
    t.e_h1 = e_h1; t.e_d1 = e_d1; t.e_h2 = e_h2; t.e_d2 = e_d2; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [4:0] wr, input logic jal,
                       input logic [31:0] d, input logic st,
                       input logic [4:0] r1, input logic [4:0] r2);
    in_valid = v; in_wr = wr; in_jal_ra = jal; in_data = d;
    wb_stall = st; rr1_in = r1; rr2_in = r2;
  endtask

  task automatic check_vec(input int n, input vec_t t);
    chk($sformatf("v%0d in_ready", n),   32'(in_ready),  32'(t.e_rdy));
    chk($sformatf("v%0d regwrite", n),   32'(regwrite),  32'(t.e_rw));
    chk($sformatf("v%0d wr_out", n),     32'(wr_out),    32'(t.e_wr));
    chk($sformatf("v%0d wdata", n),      write_data_out, t.e_wd);
    chk($sformatf("v%0d fwd1_hit", n),   32'(fwd1_hit),  32'(t.e_h1));
    chk($sformatf("v%0d fwd1_data", n),  fwd1_data,      t.e_d1);
    chk($sformatf("v%0d fwd2_hit", n),   32'(fwd2_hit),  32'(t.e_h2));
    chk($sformatf("v%0d fwd2_data", n),  fwd2_data,      t.e_d2);
    chk($sformatf("v%0d count", n),      32'(count),     32'(t.e_cnt));
  endtask

  initial begin
    // Each row: inputs driven for one cycle; expected outputs sampled before the edge.
    //            v  wr jal d             st r1  r2   rdy rw wr  wd            h1 d1            h2 d2     cnt
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));
    vecs.push_back(mk(1, 5, 0, 32'hDEADBEEF, 0, 5,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 5,  0,  1, 1, 5,  32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 5,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));
    // fill while stalled, fifth request refused until a slot frees
    vecs.push_back(mk(1, 1, 0, 32'h101,      1, 0,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));
    vecs.push_back(mk(1, 2, 0, 32'h102,      1, 0,  0,  1, 0, 1,  32'h101,      0, 32'h0,        0, 32'h0, 1));
    vecs.push_back(mk(1, 3, 0, 32'h103,      1, 0,  0,  1, 0, 1,  32'h101,      0, 32'h0,        0, 32'h0, 2));
    vecs.push_back(mk(1, 4, 0, 32'h104,      1, 0,  0,  1, 0, 1,  32'h101,      0, 32'h0,        0, 32'h0, 3));
    vecs.push_back(mk(1, 5, 0, 32'h105,      1, 3,  4,  0, 0, 1,  32'h101,      1, 32'h103,      1, 32'h104, 4));
    vecs.push_back(mk(1, 5, 0, 32'h105,      0, 0,  0,  0, 1, 1,  32'h101,      0, 32'h0,        0, 32'h0, 4));
    vecs.push_back(mk(1, 5, 0, 32'h105,      0, 0,  0,  1, 1, 2,  32'h102,      0, 32'h0,        0, 32'h0, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 5,  0,  1, 1, 3,  32'h103,      1, 32'h105,      0, 32'h0, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  1, 1, 4,  32'h104,      0, 32'h0,        0, 32'h0, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 5,  0,  1, 1, 5,  32'h105,      1, 32'h105,      0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));
    // forwarding priority: newest r7 wins, incoming r7 not visible
    vecs.push_back(mk(1, 7, 0, 32'h11,       1, 7,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));
    vecs.push_back(mk(1, 7, 0, 32'h22,       1, 7,  0,  1, 0, 7,  32'h11,       1, 32'h11,       0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 7,  0,  1, 0, 7,  32'h11,       1, 32'h22,       0, 32'h0, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 7,  0,  1, 1, 7,  32'h11,       1, 32'h22,       0, 32'h0, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 7,  0,  1, 1, 7,  32'h22,       1, 32'h22,       0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 7,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));
    // jal redirect to r31, then a write to r0 that is dropped
    vecs.push_back(mk(1, 9, 1, 32'h400,      1, 0,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h55,       1, 31, 9,  1, 0, 31, 32'h400,      1, 32'h400,      0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0,  0,  1, 0, 31, 32'h400,      0, 32'h0,        0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 31, 0,  1, 1, 31, 32'h400,      1, 32'h400,      0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0));

    // reset held across an edge with a request offered
    reset = 1'b0;
    drive(1, 3, 0, 32'h33, 0, 3, 0);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst regwrite", 32'(regwrite), 32'd0);
    chk("rst count",    32'(count),    32'd0);
    chk("rst fwd1_hit", 32'(fwd1_hit), 32'd0);
    @(negedge clock);
    chk("rst hold count", 32'(count), 32'd0);
    chk("rst hold wr_out", 32'(wr_out), 32'd0);
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    reset = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].v, vecs[n].wr, vecs[n].jal, vecs[n].d, vecs[n].st, vecs[n].r1, vecs[n].r2);
      #1;
      check_vec(n, vecs[n]);
      @(negedge clock);
    end

    // wrap-around: accept and pop every cycle, occupancy stays at one
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'((i % 8) + 1), 0, 32'hA0 + 32'(i), 0, 0, 0);
      #1;
      chk($sformatf("wrap%0d in_ready", i), 32'(in_ready), 32'd1);
      if (i == 0) begin
        chk("wrap0 count", 32'(count), 32'd0);
      end else begin
        chk($sformatf("wrap%0d count", i), 32'(count), 32'd1);
        chk($sformatf("wrap%0d regwrite", i), 32'(regwrite), 32'd1);
        chk($sformatf("wrap%0d wdata", i), write_data_out, exp_q.pop_front());
      end
      exp_q.push_back(32'hA0 + 32'(i));
      @(negedge clock);
    end
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    #1;
    chk("wrap tail count", 32'(count), 32'd1);
    chk("wrap tail wr_out", 32'(wr_out), 32'd2);
    chk("wrap tail wdata", write_data_out, exp_q.pop_front());
    @(negedge clock);
    #1;
    chk("wrap drained count", 32'(count), 32'd0);
    chk("wrap queue empty", 32'(exp_q.size()), 32'd0);
    @(negedge clock);

    // asynchronous reset mid-cycle with three entries pending
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(10 + i), 0, 32'hC0 + 32'(i), 1, 0, 0);
      @(negedge clock);
    end
    drive(0, 0, 0, 32'h0, 1, 10, 0);
    #1;
    chk("pre-reset count", 32'(count), 32'd3);
    #1;
    reset = 1'b0;
    wb_stall = 1'b0;
    #1;
    chk("async count",    32'(count),    32'd0);
    chk("async regwrite", 32'(regwrite), 32'd0);
    chk("async wr_out",   32'(wr_out),   32'd0);
    chk("async fwd1_hit", 32'(fwd1_hit), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    chk("reset low regwrite", 32'(regwrite), 32'd0);
    // first accept honoured at the first edge with reset high
    reset = 1'b1;
    drive(1, 6, 0, 32'h66, 0, 0, 0);
    #1;
    chk("post-reset count", 32'(count), 32'd0);
    @(negedge clock);
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    #1;
    chk("first accept count",    32'(count),    32'd1);
    chk("first accept regwrite", 32'(regwrite), 32'd1);
    chk("first accept wr_out",   32'(wr_out),   32'd6);
    chk("first accept wdata",    write_data_out, 32'h66);
    @(negedge clock);
    #1;
    chk("final count",    32'(count),    32'd0);
    chk("final regwrite", 32'(regwrite), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
